pad_ring_ctrl: RTL and testbench



---
 rtl/pad_ring_ctrl_if.sv | 34 +++
 rtl/pad_ring_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pad_ring_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pad_ring_ctrl_if.sv
// ---------------------------------------------------------------------------
// pad_ring_ctrl_if
// Register-access port of the pad ring controller (req/gnt with a
// one-cycle response).
//   req    : access request
//   we     : 1 = write, 0 = read
//   addr   : pad index
//   wdata  : {smt, slw, puen, drv[1:0]}
//   gnt    : access accepted this cycle (combinational on req)
//   rvalid : response valid, one cycle after gnt
//   rdata  : read data (0 for write responses), same layout as wdata
// master = bus side issuing accesses, slave = pad_ring_ctrl.
// ---------------------------------------------------------------------------
interface pad_ring_ctrl_if #(
    parameter int AW = 5
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [4:0]    wdata;
    logic          gnt;
    logic          rvalid;
    logic [4:0]    rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/pad_ring_ctrl.sv
// ---------------------------------------------------------------------------
// pad_ring_ctrl
// Sequences pad-ring power-up and retention entry/exit (PWROK, IOPWROK,
// RETC, global OEN override) and holds the per-pad static configuration
// (DRV, PUEN, SLW, SMT) behind a req/gnt register port.
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   en_i               : start power-up (looked at only in OFF)
//   ret_req_i          : retention request level
//   cfg_if             : register port (slave side)
//   pad_drv_o          : 2 bits per pad, pad p at [2p+1:2p]
//   pad_puen_o/slw/smt : 1 bit per pad
//   pad_oen_force_o    : 1 = all pad OENs forced high
//   pwrok_o, iopwrok_o, retc_o : pad-ring power-control nets
//   ready_o            : high only in ACTIVE
// ---------------------------------------------------------------------------
module pad_ring_ctrl #(
    parameter int NumPads      = 32,
    parameter int PwrokCycles  = 16,
    parameter int IopwrokCycles = 16,
    parameter int RetcCycles   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 ret_req_i,
    pad_ring_ctrl_if.slave       cfg_if,
    output logic [2*NumPads-1:0] pad_drv_o,
    output logic [NumPads-1:0]   pad_puen_o,
    output logic [NumPads-1:0]   pad_slw_o,
    output logic [NumPads-1:0]   pad_smt_o,
    output logic                 pad_oen_force_o,
    output logic                 pwrok_o,
    output logic                 iopwrok_o,
    output logic                 retc_o,
    output logic                 ready_o
);

    localparam int AW = $clog2(NumPads);
    localparam int MaxA = (PwrokCycles > IopwrokCycles) ? PwrokCycles : IopwrokCycles;
    localparam int MaxCyc = (MaxA > RetcCycles) ? MaxA : RetcCycles;
    localparam int CW = $clog2(MaxCyc + 1);

    localparam logic [CW-1:0] PwrokLoad   = CW'(PwrokCycles - 1);
    localparam logic [CW-1:0] IopwrokLoad = CW'(IopwrokCycles - 1);
    localparam logic [CW-1:0] RetcLoad    = CW'(RetcCycles - 1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PWR_UP,
        ST_IO_UP,
        ST_RET_RELEASE,
        ST_ACTIVE,
        ST_RET_ENTER,
        ST_RETENTION
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic pwrok_q, iopwrok_q, retc_q, force_q, ready_q;
    logic rvalid_q;
    logic [4:0] rdata_q;
    logic [4:0] rd_val;
    logic       cfg_gnt;
    logic [4:0] pad_cfg [NumPads];

    // ------------------------------------------------------------------
    // Sequencer next state. The dwell counter is loaded with N-1 on entry
    // to a timed state; the state is left on the cycle it reads zero.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        case (state_q)
            ST_OFF: begin
                if (en_i) begin
                    state_d = ST_PWR_UP;
                    cnt_d   = PwrokLoad;
                end
            end
            ST_PWR_UP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IO_UP;
                    cnt_d   = IopwrokLoad;
                end
            end
            ST_IO_UP: begin
                if (cnt_q == '0) begin
                    state_d = ST_RET_RELEASE;
                    cnt_d   = RetcLoad;
                end
            end
            ST_RET_RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (ret_req_i) begin
                    state_d = ST_RET_ENTER;
                    cnt_d   = RetcLoad;
                end
            end
            ST_RET_ENTER: begin
                if (cnt_q == '0) begin
                    state_d = ST_RETENTION;
                end
            end
            ST_RETENTION: begin
                if (!ret_req_i) begin
                    state_d = ST_RET_RELEASE;
                    cnt_d   = RetcLoad;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Pad-net outputs are flops loaded from the next state, so they change
    // on the same edge as the state and never glitch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            pwrok_q   <= 1'b0;
            iopwrok_q <= 1'b0;
            retc_q    <= 1'b1;
            force_q   <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pwrok_q   <= (state_d != ST_OFF);
            iopwrok_q <= (state_d != ST_OFF) && (state_d != ST_PWR_UP);
            retc_q    <= (state_d != ST_RET_RELEASE) && (state_d != ST_ACTIVE);
            force_q   <= (state_d != ST_ACTIVE);
            ready_q   <= (state_d == ST_ACTIVE);
        end
    end

    assign pwrok_o         = pwrok_q;
    assign iopwrok_o       = iopwrok_q;
    assign retc_o          = retc_q;
    assign pad_oen_force_o = force_q;
    assign ready_o         = ready_q;

    // ------------------------------------------------------------------
    // Register port. Config is frozen while entering or in retention.
    // ------------------------------------------------------------------
    assign cfg_gnt    = cfg_if.req && (state_q != ST_RET_ENTER) && (state_q != ST_RETENTION);
    assign cfg_if.gnt = cfg_gnt;

    // Per-pad config flops. An address beyond the last pad matches no
    // pad, so such writes are dropped naturally.
    genvar gi;
    generate
        for (gi = 0; gi < NumPads; gi++) begin : g_pad
            logic [4:0] cfg_q;
            logic       wr_hit;

            assign wr_hit = cfg_gnt && cfg_if.we && (cfg_if.addr == AW'(gi));

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cfg_q <= '0;
                end else if (wr_hit) begin
                    cfg_q <= cfg_if.wdata;
                end
            end

            assign pad_cfg[gi]          = cfg_q;
            assign pad_drv_o[2*gi +: 2] = cfg_q[1:0];
            assign pad_puen_o[gi]       = cfg_q[2];
            assign pad_slw_o[gi]        = cfg_q[3];
            assign pad_smt_o[gi]        = cfg_q[4];
        end
    endgenerate

    // Read mux; an unmatched address reads as zero.
    always_comb begin
        rd_val = '0;
        for (int p = 0; p < NumPads; p++) begin
            if (cfg_if.addr == AW'(p)) begin
                rd_val = pad_cfg[p];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= cfg_gnt;
            rdata_q  <= (cfg_gnt && !cfg_if.we) ? rd_val : 5'd0;
        end
    end

    assign cfg_if.rvalid = rvalid_q;
    assign cfg_if.rdata  = rdata_q;

endmodule

// File: tb/tb_pad_ring_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pad_ring_ctrl
// Bench for pad_ring_ctrl: power-up and retention timing, config access via
// a response scoreboard, out-of-range addressing on a 20-pad instance and
// asynchronous reset at several points.
// ---------------------------------------------------------------------------
module tb_pad_ring_ctrl;

    localparam int NP  = 32;
    localparam int NP2 = 20;
    localparam int AW  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic ret_req = 1'b0;

    always #5 clk = ~clk;

    pad_ring_ctrl_if #(.AW(AW)) bus ();
    pad_ring_ctrl_if #(.AW(AW)) bus20 ();

    logic [2*NP-1:0] drv;
    logic [NP-1:0]   puen, slw, smt;
    logic            oen_force, pwrok, iopwrok, retc, ready;

    logic [2*NP2-1:0] drv20;
    logic [NP2-1:0]   puen20, slw20, smt20;
    logic             oen_force20, pwrok20, iopwrok20, retc20, ready20;

    pad_ring_ctrl #(.NumPads(NP)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .ret_req_i(ret_req),
        .cfg_if(bus.slave),
        .pad_drv_o(drv), .pad_puen_o(puen), .pad_slw_o(slw), .pad_smt_o(smt),
        .pad_oen_force_o(oen_force), .pwrok_o(pwrok), .iopwrok_o(iopwrok),
        .retc_o(retc), .ready_o(ready)
    );

    pad_ring_ctrl #(.NumPads(NP2)) dut20 (
        .clk_i(clk), .rst_i(rst), .en_i(1'b0), .ret_req_i(1'b0),
        .cfg_if(bus20.slave),
        .pad_drv_o(drv20), .pad_puen_o(puen20), .pad_slw_o(slw20), .pad_smt_o(smt20),
        .pad_oen_force_o(oen_force20), .pwrok_o(pwrok20), .iopwrok_o(iopwrok20),
        .retc_o(retc20), .ready_o(ready20)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        logic [4:0] data;
    } exp_t;
    exp_t sb_q[$];

    logic [4:0] model [NP];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every cycle either the oldest expected response is
    // due, or rvalid must be low.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                check_val("rvalid", 64'(bus.rvalid), 64'd1);
                check_val("rdata", 64'(bus.rdata), 64'(sb_q[0].data));
                void'(sb_q.pop_front());
            end else begin
                check_val("rvalid_idle", 64'(bus.rvalid), 64'd0);
            end
        end
    end

    function automatic logic [63:0] m_drv();
        logic [63:0] r = '0;
        for (int p = 0; p < NP; p++) r[2*p +: 2] = model[p][1:0];
        return r;
    endfunction

    function automatic logic [31:0] m_bit(input int b);
        logic [31:0] r = '0;
        for (int p = 0; p < NP; p++) r[p] = model[p][b];
        return r;
    endfunction

    task automatic check_pads(input string tag);
        check_val({tag, "_drv"}, drv, m_drv());
        check_val({tag, "_puen"}, 64'(puen), 64'(m_bit(2)));
        check_val({tag, "_slw"}, 64'(slw), 64'(m_bit(3)));
        check_val({tag, "_smt"}, 64'(smt), 64'(m_bit(4)));
    endtask

    // {pwrok, iopwrok, retc, force, ready}
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check_val(tag, 64'({pwrok, iopwrok, retc, oen_force, ready}), 64'(exp));
    endtask

    task automatic cfg_op(input logic we, input logic [4:0] addr, input logic [4:0] wd,
                          input logic exp_gnt);
        bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wd;
        #1;
        check_val($sformatf("gnt_a%0d", addr), 64'(bus.gnt), 64'(exp_gnt));
        if (exp_gnt) begin
            sb_q.push_back('{due: cyc + 1, data: (we ? 5'd0 : model[addr])});
            if (we) model[addr] = wd;
        end
        tick();
        bus.req = 1'b0; bus.we = 1'b0;
    endtask

    task automatic run_powerup();
        en = 1'b1;
        for (int n = 0; n <= 41; n++) begin
            tick();
            if (n == 0) en = 1'b0;
            check_ctl($sformatf("pu_edge%0d", n),
                      {1'b1, (n >= 16), (n < 32), (n < 40), (n >= 40)});
        end
    endtask

    // Assert reset mid-cycle and confirm outputs return at once.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        sb_q.delete();
        for (int p = 0; p < NP; p++) model[p] = '0;
        #1;
        check_ctl({tag, "_ctl"}, 5'b00110);
        check_val({tag, "_rvalid"}, 64'(bus.rvalid), 64'd0);
        check_val({tag, "_rdata"}, 64'(bus.rdata), 64'd0);
        check_pads(tag);
        ret_req = 1'b0;
        en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus20.req = 1'b0; bus20.we = 1'b0; bus20.addr = '0; bus20.wdata = '0;
        for (int p = 0; p < NP; p++) model[p] = '0;

        // Reset state
        repeat (3) tick();
        check_ctl("rst_ctl", 5'b00110);
        check_val("rst_gnt", 64'(bus.gnt), 64'd0);
        check_val("rst_rvalid", 64'(bus.rvalid), 64'd0);
        check_val("rst_rdata", 64'(bus.rdata), 64'd0);
        check_pads("rst");
        rst = 1'b0;
        tick();

        // Power-up sequence with default dwell times
        run_powerup();

        // Config write/read of pad 5
        cfg_op(1'b1, 5'd5, 5'b10111, 1'b1);
        check_val("p5_drv", 64'(drv[11:10]), 64'd3);
        check_val("p5_puen", 64'(puen[5]), 64'd1);
        check_val("p5_slw", 64'(slw[5]), 64'd0);
        check_val("p5_smt", 64'(smt[5]), 64'd1);
        check_pads("after_w5");
        cfg_op(1'b0, 5'd5, 5'd0, 1'b1);

        // Back-to-back accesses, including the last pad
        cfg_op(1'b1, 5'd31, 5'h1F, 1'b1);
        cfg_op(1'b1, 5'd3, 5'b01010, 1'b1);
        cfg_op(1'b0, 5'd31, 5'd0, 1'b1);
        cfg_op(1'b0, 5'd3, 5'd0, 1'b1);
        cfg_op(1'b0, 5'd9, 5'd0, 1'b1);
        tick();
        check_val("p31_drv", 64'(drv[63:62]), 64'd3);
        check_pads("after_b2b");

        // Retention entry/exit with blocked config writes
        ret_req = 1'b1;
        tick();
        check_ctl("ret_m0", 5'b11110);
        for (int k = 1; k <= 18; k++) begin
            if (k <= 8) begin
                bus.req = 1'b1; bus.we = 1'b1; bus.addr = 5'd5; bus.wdata = 5'd0;
                #1;
                check_val($sformatf("ret_gnt%0d", k), 64'(bus.gnt), 64'd0);
            end
            if (k == 5) ret_req = 1'b0;
            tick();
            bus.req = 1'b0; bus.we = 1'b0;
            check_ctl($sformatf("ret_m%0d", k), {1'b1, 1'b1, (k < 9), (k < 17), (k >= 17)});
        end
        check_pads("after_ret");

        // Write and retention request in the same ACTIVE cycle
        ret_req = 1'b1;
        cfg_op(1'b1, 5'd0, 5'b00001, 1'b1);
        ret_req = 1'b0;
        check_val("sim_drv0", 64'(drv[1:0]), 64'd1);
        check_ctl("sim_ctl", 5'b11110);
        check_pads("after_sim");
        repeat (17) tick();
        check_ctl("sim_back", 5'b11001);

        // Out-of-range address on the 20-pad instance
        bus20.req = 1'b1; bus20.we = 1'b1; bus20.addr = 5'd25; bus20.wdata = 5'h1F;
        #1;
        check_val("oor_w_gnt", 64'(bus20.gnt), 64'd1);
        tick();
        bus20.req = 1'b0; bus20.we = 1'b0;
        check_val("oor_w_rvalid", 64'(bus20.rvalid), 64'd1);
        check_val("oor_w_rdata", 64'(bus20.rdata), 64'd0);
        check_val("oor_drv", 64'(drv20), 64'd0);
        check_val("oor_bits", 64'({puen20, slw20, smt20}), 64'd0);
        bus20.req = 1'b1; bus20.we = 1'b1; bus20.addr = 5'd19; bus20.wdata = 5'b00110;
        tick();
        bus20.we = 1'b0; bus20.addr = 5'd25;
        check_val("p19_drv", 64'(drv20), 64'(40'd2 << 38));
        check_val("p19_puen", 64'(puen20), 64'(20'h80000));
        tick();
        bus20.req = 1'b0;
        check_val("oor_r_rvalid", 64'(bus20.rvalid), 64'd1);
        check_val("oor_r_rdata", 64'(bus20.rdata), 64'd0);

        // Reset during IO_UP
        async_reset("rst_pre");
        en = 1'b1;
        tick();
        en = 1'b0;
        repeat (20) tick();
        check_ctl("io_up", 5'b11110);
        async_reset("rst_ioup");

        // Reset with a read response pending
        cfg_op(1'b1, 5'd7, 5'h15, 1'b1);
        cfg_op(1'b0, 5'd7, 5'd0, 1'b1);
        check_val("pend_rvalid", 64'(bus.rvalid), 64'd1);
        check_val("pend_rdata", 64'(bus.rdata), 64'h15);
        async_reset("rst_pend");

        // Reset during RETENTION
        run_powerup();
        ret_req = 1'b1;
        repeat (10) tick();
        check_ctl("in_ret", 5'b11110);
        async_reset("rst_ret");

        // Full sequence after reset
        run_powerup();
        tick();
        check_val("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
